// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the types used by the execute-stage
// multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV} mdu_state_e;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } mdu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Operates on magnitudes; signs are reapplied on the final iteration edge.
import mips_pkg::*;

module mdu_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg_hi, neg_lo;

  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, div_r, div_diff;
  logic        div_ge;
  logic [63:0] mul_nxt, div_nxt, prod;
  logic        unused_diff;

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    a_abs    = abs_if(a, op.is_signed);
    b_abs    = abs_if(b, op.is_signed);
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_nxt  = {mul_sum, acc[31:1]};
    div_r    = {acc[63:32], acc[31]};
    div_ge   = div_r >= {1'b0, opnd};
    div_diff = div_r - {1'b0, opnd};
    div_nxt  = div_ge ? {div_diff[31:0], acc[30:0], 1'b1} : {div_r[31:0], acc[30:0], 1'b0};
    prod     = neg_lo ? -mul_nxt : mul_nxt;
  end

  assign unused_diff = div_diff[32];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = op.is_div ? DIV : MUL;
      MUL,
      DIV:     if (cnt == 5'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= 5'd31;
            acc    <= {32'd0, op.is_div ? a_abs : b_abs};
            opnd   <= op.is_div ? b_abs : a_abs;
            // divide-by-zero keeps an all-ones quotient and the raw dividend as remainder
            neg_lo <= op.is_signed & (a[31] ^ b[31]) & (~op.is_div | (b != '0));
            neg_hi <= op.is_signed & a[31];
          end else begin
            if (hi_wr) hi <= wdata;
            if (lo_wr) lo <= wdata;
          end
        end
        MUL: begin
          acc <= mul_nxt;
          if (cnt == 5'd0) {hi, lo} <= prod;
          else             cnt <= cnt - 5'd1;
        end
        DIV: begin
          acc <= div_nxt;
          if (cnt == 5'd0) begin
            lo <= neg_lo ? -div_nxt[31:0]  : div_nxt[31:0];
            hi <= neg_hi ? -div_nxt[63:32] : div_nxt[63:32];
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: single-cycle ALU with registered Result/Zero/Ovf, plus the
// iterative multiply/divide unit that stalls upstream via Busy.
import mips_pkg::*;

module ex_mdu (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [31:0] Ed32,
  output logic        Busy,
  output logic [31:0] Result,
  output logic        ResValid,
  output logic        Zero,
  output logic        Ovf
);

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic        accept;
  logic [31:0] sum, diff, isum, hi, lo, alu;
  logic        ovf_add, ovf_sub, ovf_addi;
  logic        known, res_ok, ovf, hi_wr, lo_wr, md_start;
  mdu_op_t     md_op;
  logic        unused_ins;

  assign opcode     = Ins[31:26];
  assign shamt      = Ins[10:6];
  assign funct      = Ins[5:0];
  assign unused_ins = ^Ins[25:11];
  assign accept     = Valid & ~Busy;

  assign sum      = Rdata1 + Rdata2;
  assign diff     = Rdata1 - Rdata2;
  assign isum     = Rdata1 + Ed32;
  assign ovf_add  = (Rdata1[31] == Rdata2[31]) && (sum[31]  != Rdata1[31]);
  assign ovf_sub  = (Rdata1[31] != Rdata2[31]) && (diff[31] != Rdata1[31]);
  assign ovf_addi = (Rdata1[31] == Ed32[31])   && (isum[31] != Rdata1[31]);

  always_comb begin
    alu      = '0;
    known    = 1'b0;
    res_ok   = 1'b0;
    ovf      = 1'b0;
    hi_wr    = 1'b0;
    lo_wr    = 1'b0;
    md_start = 1'b0;
    md_op    = '0;
    case (opcode)
      OP_RTYPE: begin
        known  = 1'b1;
        res_ok = 1'b1;
        case (funct)
          FN_ADD:   begin alu = sum;  ovf = ovf_add; res_ok = ~ovf_add; end
          FN_ADDU:  alu = sum;
          FN_SUB:   begin alu = diff; ovf = ovf_sub; res_ok = ~ovf_sub; end
          FN_SUBU:  alu = diff;
          FN_AND:   alu = Rdata1 & Rdata2;
          FN_OR:    alu = Rdata1 | Rdata2;
          FN_XOR:   alu = Rdata1 ^ Rdata2;
          FN_NOR:   alu = ~(Rdata1 | Rdata2);
          FN_SLT:   alu = {31'd0, $signed(Rdata1) < $signed(Rdata2)};
          FN_SLTU:  alu = {31'd0, Rdata1 < Rdata2};
          FN_SLL:   alu = Rdata2 << shamt;
          FN_SRL:   alu = Rdata2 >> shamt;
          FN_SRA:   alu = $signed(Rdata2) >>> shamt;
          FN_MFHI:  alu = hi;
          FN_MFLO:  alu = lo;
          FN_MTHI:  begin res_ok = 1'b0; hi_wr = 1'b1; end
          FN_MTLO:  begin res_ok = 1'b0; lo_wr = 1'b1; end
          FN_MULT:  begin res_ok = 1'b0; md_start = 1'b1; md_op.is_signed = 1'b1; end
          FN_MULTU: begin res_ok = 1'b0; md_start = 1'b1; end
          FN_DIV:   begin res_ok = 1'b0; md_start = 1'b1; md_op = '1; end
          FN_DIVU:  begin res_ok = 1'b0; md_start = 1'b1; md_op.is_div = 1'b1; end
          default:  begin known = 1'b0; res_ok = 1'b0; end
        endcase
      end
      OP_BEQ, OP_BNE: known = 1'b1;
      OP_ADDI:  begin known = 1'b1; alu = isum; ovf = ovf_addi; res_ok = ~ovf_addi; end
      OP_ADDIU, OP_LW, OP_SW: begin known = 1'b1; res_ok = 1'b1; alu = isum; end
      OP_SLTI:  begin known = 1'b1; res_ok = 1'b1; alu = {31'd0, $signed(Rdata1) < $signed(Ed32)}; end
      OP_SLTIU: begin known = 1'b1; res_ok = 1'b1; alu = {31'd0, Rdata1 < Ed32}; end
      OP_ANDI:  begin known = 1'b1; res_ok = 1'b1; alu = Rdata1 & {16'd0, Ed32[15:0]}; end
      OP_ORI:   begin known = 1'b1; res_ok = 1'b1; alu = Rdata1 | {16'd0, Ed32[15:0]}; end
      OP_XORI:  begin known = 1'b1; res_ok = 1'b1; alu = Rdata1 ^ {16'd0, Ed32[15:0]}; end
      OP_LUI:   begin known = 1'b1; res_ok = 1'b1; alu = {Ed32[15:0], 16'd0}; end
      default: ;
    endcase
  end

  mdu_iter u_mdu (
    .clk   (CLK),
    .rst_n (RST),
    .start (accept & md_start),
    .op    (md_op),
    .a     (Rdata1),
    .b     (Rdata2),
    .hi_wr (accept & hi_wr),
    .lo_wr (accept & lo_wr),
    .wdata (Rdata1),
    .busy  (Busy),
    .hi    (hi),
    .lo    (lo)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Result   <= '0;
      ResValid <= 1'b0;
      Zero     <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      ResValid <= accept & res_ok;
      Ovf      <= accept & ovf;
      if (accept & res_ok) Result <= alu;
      if (accept & known)  Zero   <= (Rdata1 == Rdata2);
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized self-checking bench for ex_mdu against an arithmetic reference model.
module tb_ex_mdu;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Valid = 1'b0;
  logic [31:0] Ins = '0, Rdata1 = '0, Rdata2 = '0, Ed32 = '0;
  logic        Busy, ResValid, Zero, Ovf;
  logic [31:0] Result;

  ex_mdu dut (
    .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins), .Rdata1(Rdata1),
    .Rdata2(Rdata2), .Ed32(Ed32), .Busy(Busy), .Result(Result),
    .ResValid(ResValid), .Zero(Zero), .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;
  logic        m_zero = 1'b0;

  // {opcode, funct}; funct ignored for I-types
  logic [11:0] optab [0:36] = '{
    {6'h00,6'h20},{6'h00,6'h21},{6'h00,6'h22},{6'h00,6'h23},{6'h00,6'h24},
    {6'h00,6'h25},{6'h00,6'h26},{6'h00,6'h27},{6'h00,6'h2A},{6'h00,6'h2B},
    {6'h00,6'h00},{6'h00,6'h02},{6'h00,6'h03},{6'h00,6'h10},{6'h00,6'h12},
    {6'h00,6'h11},{6'h00,6'h13},{6'h00,6'h18},{6'h00,6'h19},{6'h00,6'h1A},
    {6'h00,6'h1B},{6'h04,6'h00},{6'h05,6'h00},{6'h08,6'h00},{6'h09,6'h00},
    {6'h0A,6'h00},{6'h0B,6'h00},{6'h0C,6'h00},{6'h0D,6'h00},{6'h0E,6'h00},
    {6'h0F,6'h00},{6'h23,6'h00},{6'h2B,6'h00},{6'h00,6'h01},{6'h00,6'h3F},
    {6'h02,6'h00},{6'h3F,6'h00}
  };

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [5:0] opc, input logic [5:0] fn);
    logic [31:0] r;
    r = $urandom;
    if (opc == 6'h00) return {6'h00, r[25:6], fn};
    return {opc, r[25:0]};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (Busy === 1'b1 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 100) check_eq("idle_timeout", 32'(Busy), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input bit hammer);
    logic [5:0]  opc;
    logic [5:0]  fn;
    int          sh;
    longint      sa, sb, si, s;
    logic [63:0] p;
    bit          known, md, rv, ov;
    logic [31:0] res, nhi, nlo;
    int          n;
    bit          rv_seen;
    opc = ins[31:26]; fn = ins[5:0]; sh = int'(ins[10:6]);
    sa = longint'($signed(r1)); sb = longint'($signed(r2)); si = longint'($signed(imm));
    known = 1; md = 0; rv = 0; ov = 0; res = '0; nhi = m_hi; nlo = m_lo;
    case (opc)
      6'h00: case (fn)
        6'h20: begin s = sa + sb; ov = (s > MAXI) || (s < MINI); rv = !ov; res = 32'(s); end
        6'h21: begin rv = 1; res = r1 + r2; end
        6'h22: begin s = sa - sb; ov = (s > MAXI) || (s < MINI); rv = !ov; res = 32'(s); end
        6'h23: begin rv = 1; res = r1 - r2; end
        6'h24: begin rv = 1; res = r1 & r2; end
        6'h25: begin rv = 1; res = r1 | r2; end
        6'h26: begin rv = 1; res = r1 ^ r2; end
        6'h27: begin rv = 1; res = ~(r1 | r2); end
        6'h2A: begin rv = 1; res = (sa < sb) ? 32'd1 : 32'd0; end
        6'h2B: begin rv = 1; res = (r1 < r2) ? 32'd1 : 32'd0; end
        6'h00: begin rv = 1; res = r2 << sh; end
        6'h02: begin rv = 1; res = r2 >> sh; end
        6'h03: begin rv = 1; res = 32'(sb >>> sh); end
        6'h10: begin rv = 1; res = m_hi; end
        6'h12: begin rv = 1; res = m_lo; end
        6'h11: nhi = r1;
        6'h13: nlo = r1;
        6'h18: begin md = 1; p = 64'(sa * sb); {nhi, nlo} = p; end
        6'h19: begin md = 1; p = {32'd0, r1} * {32'd0, r2}; {nhi, nlo} = p; end
        6'h1A: begin
          md = 1;
          if (r2 == 0) begin nlo = '1; nhi = r1; end
          else begin nlo = 32'(sa / sb); nhi = 32'(sa % sb); end
        end
        6'h1B: begin
          md = 1;
          if (r2 == 0) begin nlo = '1; nhi = r1; end
          else begin nlo = r1 / r2; nhi = r1 % r2; end
        end
        default: known = 0;
      endcase
      6'h04, 6'h05: ;
      6'h08: begin s = sa + si; ov = (s > MAXI) || (s < MINI); rv = !ov; res = 32'(s); end
      6'h09, 6'h23, 6'h2B: begin rv = 1; res = r1 + imm; end
      6'h0A: begin rv = 1; res = (sa < si) ? 32'd1 : 32'd0; end
      6'h0B: begin rv = 1; res = (r1 < imm) ? 32'd1 : 32'd0; end
      6'h0C: begin rv = 1; res = r1 & {16'd0, imm[15:0]}; end
      6'h0D: begin rv = 1; res = r1 | {16'd0, imm[15:0]}; end
      6'h0E: begin rv = 1; res = r1 ^ {16'd0, imm[15:0]}; end
      6'h0F: begin rv = 1; res = {imm[15:0], 16'd0}; end
      default: known = 0;
    endcase

    wait_idle();
    Ins = ins; Rdata1 = r1; Rdata2 = r2; Ed32 = imm; Valid = 1'b1;
    @(posedge CLK); #1;
    Valid = 1'b0;
    if (rv) m_res = res;
    if (known) m_zero = (r1 == r2);

    if (md) begin
      check_eq("busy_start", 32'(Busy), 32'd1);
      n = 0; rv_seen = 0;
      while (Busy === 1'b1 && n < 100) begin
        if (hammer) begin
          logic [11:0] e;
          e = optab[$urandom_range(0, 36)];
          Ins = mk_ins(e[11:6], e[5:0]); Rdata1 = $urandom; Rdata2 = $urandom; Ed32 = $urandom;
          Valid = 1'b1;
        end
        @(posedge CLK); #1;
        rv_seen |= (ResValid === 1'b1);
        n++;
      end
      Valid = 1'b0;
      check_eq("busy_cycles", 32'(n), 32'd32);
      check_eq("md_resvalid", 32'(rv_seen), 32'd0);
      check_eq("md_result_hold", Result, m_res);
      m_hi = nhi; m_lo = nlo;
    end else begin
      m_hi = nhi; m_lo = nlo;
      check_eq($sformatf("resvalid_%02h_%02h", opc, fn), 32'(ResValid), 32'(rv));
      check_eq($sformatf("ovf_%02h_%02h", opc, fn), 32'(Ovf), 32'(ov));
      check_eq($sformatf("result_%02h_%02h", opc, fn), Result, m_res);
      check_eq($sformatf("zero_%02h_%02h", opc, fn), 32'(Zero), 32'(m_zero));
      check_eq("busy_low", 32'(Busy), 32'd0);
    end
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    check_eq("idle_resvalid", 32'(ResValid), 32'd0);
    check_eq("idle_ovf", 32'(Ovf), 32'd0);
    check_eq("idle_result", Result, m_res);
  endtask

  task automatic read_hilo();
    run_op(mk_ins(6'h00, 6'h10), $urandom, $urandom, $urandom, 0);
    run_op(mk_ins(6'h00, 6'h12), $urandom, $urandom, $urandom, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_result", Result, 32'd0);
    check_eq("rst_resvalid", 32'(ResValid), 32'd0);
    check_eq("rst_zero", 32'(Zero), 32'd0);
    check_eq("rst_ovf", 32'(Ovf), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    read_hilo();

    run_op(mk_ins(6'h00, 6'h20), 32'd5, 32'd3, 32'd0, 0);
    run_op(mk_ins(6'h08, 6'h00), 32'h7FFFFFFF, 32'd9, 32'd1, 0);
    idle_cycle();
    run_op(mk_ins(6'h09, 6'h00), 32'h7FFFFFFF, 32'd9, 32'd1, 0);
    run_op(mk_ins(6'h00, 6'h22), 32'h80000000, 32'd1, 32'd0, 0);
    run_op(mk_ins(6'h04, 6'h00), 32'd7, 32'd7, 32'd0, 0);
    run_op(mk_ins(6'h00, 6'h18), 32'hFFFFFFFD, 32'd7, 32'd0, 1);
    read_hilo();
    run_op(mk_ins(6'h00, 6'h1B), 32'd100, 32'd7, 32'd0, 0);
    read_hilo();
    run_op(mk_ins(6'h00, 6'h1A), 32'hFFFFFFF9, 32'd2, 32'd0, 0);
    read_hilo();
    run_op(mk_ins(6'h00, 6'h1A), 32'h12345678, 32'd0, 32'd0, 0);
    read_hilo();
    run_op(mk_ins(6'h00, 6'h11), 32'hA5A5A5A5, 32'd0, 32'd0, 0);
    run_op(mk_ins(6'h00, 6'h13), 32'h5A5A5A5A, 32'd1, 32'd0, 0);
    read_hilo();

    // reset in the middle of a divu
    wait_idle();
    Ins = mk_ins(6'h00, 6'h1B); Rdata1 = 32'd100; Rdata2 = 32'd7; Valid = 1'b1;
    @(posedge CLK); #1;
    Valid = 1'b0;
    repeat (9) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check_eq("abort_busy", 32'(Busy), 32'd0);
    check_eq("abort_result", Result, 32'd0);
    check_eq("abort_zero", 32'(Zero), 32'd0);
    m_hi = '0; m_lo = '0; m_res = '0; m_zero = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    read_hilo();

    for (int i = 0; i < 160; i++) begin
      logic [11:0] e;
      logic [31:0] a, b, imm;
      e = optab[$urandom_range(0, 36)];
      a = pick_val();
      b = ($urandom_range(0, 4) == 0) ? a : pick_val();
      imm = ($urandom_range(0, 2) == 0) ? pick_val() : 32'($signed($urandom_range(0, 65535) - 32768));
      run_op(mk_ins(e[11:6], e[5:0]), a, b, imm, bit'($urandom_range(0, 1)));
      if (e[11:6] == 6'h00 && e[5:3] == 3'b011) read_hilo();
      else if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have port: CLK  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: RST  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: Valid  input  1  Ins/operands from decode stage are valid this cycle.
REQ-004 SHALL have port: Ins  input  32  instruction word (opcode [31:26], shamt [10:6], funct [5:0]).
REQ-005 SHALL have port: Rdata1  input  32  rs operand from register file.
REQ-006 SHALL have port: Rdata2  input  32  rt operand from register file.
REQ-007 SHALL have port: Ed32  input  32  sign-extended immediate.
REQ-008 SHALL have port: Busy  output  1  iterative mult/div in progress; upstream holds inputs.
REQ-009 SHALL have port: Result  output  32  registered ALU/address/move result.
REQ-010 SHALL have port: ResValid  output  1  Result holds a new value this cycle (1-cycle pulse).
REQ-011 SHALL have port: Zero  output  1  registered (Rdata1 == Rdata2) for the last accepted op.
REQ-012 SHALL have port: Ovf  output  1  1-cycle pulse, signed overflow on add/sub/addi.

Function
REQ-013 SHALL accept an instruction only on a rising edge with Valid=1 and Busy=0; other inputs are ignored.
REQ-014 Single-cycle ops SHALL register Result, assert ResValid and update Zero on the accept edge (latency 1): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, addi, addiu, slti, sltiu, andi/ori/xori (zero-extend Ed32[15:0]), lui (Ed32[15:0]<<16), lw/sw (Rdata1+Ed32), mfhi, mflo.
REQ-015 beq/bne SHALL update only Zero; ResValid SHALL stay 0.
REQ-016 add/sub/addi with signed overflow SHALL pulse Ovf=1 and ResValid=0; Result SHALL keep its previous value.
REQ-017 Opcodes/functs not listed SHALL produce ResValid=0, Ovf=0 and no state change.
REQ-018 mthi/mtlo SHALL write Rdata1 to HI/LO on the accept edge; ResValid=0.
REQ-019 mult/multu/div/divu SHALL start the iterative unit; FSM states IDLE, MUL, DIV; IDLE->MUL/DIV on accept; counter loads 31 and decrements each cycle; MUL/DIV->IDLE on the edge where counter is 0.
REQ-020 Busy SHALL equal (state != IDLE): high for exactly 32 cycles after the accept edge.
REQ-021 HI/LO SHALL update only on the final iteration edge; mult/div SHALL never assert ResValid.
REQ-022 mult/multu SHALL produce the 64-bit product {HI,LO}, signed or unsigned per opcode.
REQ-023 div/divu: LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-024 Division by zero SHALL still take 32 cycles and yield LO=0xFFFFFFFF, HI=dividend.
REQ-025 mfhi/mflo accepted on the cycle Busy falls SHALL return the new HI/LO.

Reset
REQ-026 RST=0 SHALL asynchronously force: state IDLE, counter 0, HI=0, LO=0, Result=0, ResValid=0, Zero=0, Ovf=0, Busy=0.
REQ-027 Reset during MUL/DIV SHALL abort the operation; HI/LO SHALL read 0 after release.

Structure
REQ-028 Opcode/funct constants and the FSM state encoding SHALL live in shared package mips_pkg.
REQ-029 Iterative shift-add multiplier / restoring divider, FSM and HI/LO SHALL be sub-module mdu_iter; ALU and result registers stay in ex_mdu.

Verification
REQ-030 add, Rdata1=5, Rdata2=3 -> next edge Result=0x00000008, ResValid=1, Zero=0.
REQ-031 addi, Rdata1=0x7FFFFFFF, Ed32=1 -> Ovf pulse 1, ResValid=0, Result unchanged; addiu same operands -> Result=0x80000000.
REQ-032 mult, Rdata1=0xFFFFFFFD (-3), Rdata2=7 -> Busy high 32 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFEB; Valid during Busy ignored.
REQ-033 divu 100/7 -> LO=14, HI=2; div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 div, Rdata1=0x12345678, Rdata2=0 -> after 32 cycles LO=0xFFFFFFFF, HI=0x12345678.
REQ-035 RST=0 at cycle 10 of a divu -> Busy=0 immediately; after release mfhi=0, mflo=0.
